fp_mul_sequencer: RTL and testbench

- Multi-cycle controller that sequences one IEEE-754 single-precision multiply through zero check, exponent add, iterative shift-add mantissa multiply, normalize and round.
- Owns the shared shift-add mantissa datapath internally.
- Accepts operands on a valid/ready handshake and returns a product plus exception flags on a second valid/ready handshake.
- Sits between operand producers and the result consumer of the floating-point multiplier path; one operation in flight at a time.

---
 rtl/fp_mul_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_fp_mul_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_sequencer
//  Purpose  : Multi-cycle IEEE-754 single-precision multiplier controller.
//             Sequences zero/special check, exponent add, shift-add mantissa
//             multiply (ITER_BITS multiplier bits per cycle), normalize and
//             round-to-nearest-even. Denormal inputs and results flush to zero.
//  Options  : FPM_PERF_CNT_EN adds op_count / busy_cycles counters.
//  Revision : 1.0  initial release
// ============================================================================
module fp_mul_sequencer #(
    parameter int ITER_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] product,
    output logic        overflow,
    output logic        underflow,
    output logic        out_valid,
    input  logic        out_ready
`ifdef FPM_PERF_CNT_EN
    ,
    output logic [31:0] op_count,
    output logic [31:0] busy_cycles
`endif
);

    localparam int          c_N    = 24 / ITER_BITS;
    localparam logic [4:0]  c_LAST = 5'(c_N - 1);
    localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CHECK = 3'd1;
    localparam logic [2:0] c_EXP   = 3'd2;
    localparam logic [2:0] c_MUL   = 3'd3;
    localparam logic [2:0] c_NORM  = 3'd4;
    localparam logic [2:0] c_ROUND = 3'd5;
    localparam logic [2:0] c_DONE  = 3'd6;

    logic [2:0]        r_state, w_next;
    logic [31:0]       r_a, r_b;
    logic signed [9:0] r_exp;
    logic [47:0]       r_mcand;
    logic [23:0]       r_mplier;
    logic [47:0]       r_acc;
    logic [4:0]        r_cnt;
    logic [22:0]       r_frac;     // normalized fraction, hidden bit implicit
    logic              r_guard, r_sticky;
    logic [31:0]       r_product;
    logic              r_overflow, r_underflow;

    // Operand classification from the latched operands
    logic [7:0] w_ea, w_eb;
    logic       w_sign, w_any_zero, w_any_max, w_nan_res;
    assign w_ea       = r_a[30:23];
    assign w_eb       = r_b[30:23];
    assign w_sign     = r_a[31] ^ r_b[31];
    assign w_any_zero = (w_ea == 8'd0) || (w_eb == 8'd0);
    assign w_any_max  = (w_ea == 8'hFF) || (w_eb == 8'hFF);
    // inf*zero (zero includes flushed denormals) and any NaN give the quiet NaN
    assign w_nan_res  = ((w_ea == 8'hFF) && (r_a[22:0] != 23'd0)) ||
                        ((w_eb == 8'hFF) && (r_b[22:0] != 23'd0)) || w_any_zero;

    // Rounding: increment on guard when sticky or the LSB is odd
    logic              w_inc, w_carry;
    logic [23:0]       w_frac_sum;
    logic signed [9:0] w_exp_rnd;
    assign w_inc      = r_guard & (r_sticky | r_frac[0]);
    assign w_frac_sum = {1'b0, r_frac} + {23'd0, w_inc};
    assign w_carry    = w_frac_sum[23];   // 1.111..1 + ulp -> 10.0, fraction already zero
    assign w_exp_rnd  = r_exp + (w_carry ? 10'sd1 : 10'sd0);

    // Sum of the ITER_BITS partial products selected by the low multiplier bits
    logic [47:0] w_pp;
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < ITER_BITS; j++) begin
            if (r_mplier[j]) begin
                w_pp = w_pp + (r_mcand << j);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            c_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = c_CHECK;
            end
            c_CHECK: w_next = (w_any_max || w_any_zero) ? c_DONE : c_EXP;
            c_EXP:   w_next = c_MUL;
            c_MUL:   if (r_cnt == c_LAST) w_next = c_NORM;
            c_NORM:  w_next = c_ROUND;
            c_ROUND: w_next = c_DONE;
            c_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = c_IDLE;
            end
            default: w_next = c_IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add multiply, normalize, round
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_exp       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_frac      <= '0;
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
            r_product   <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_a         <= input_a;
                        r_b         <= input_b;
                        r_product   <= '0;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                    end
                end
                c_CHECK: begin
                    if (w_any_max) begin
                        r_product <= w_nan_res ? c_QNAN : {w_sign, 8'hFF, 23'd0};
                    end else if (w_any_zero) begin
                        r_product <= {w_sign, 31'd0};
                    end
                end
                c_EXP: begin
                    r_exp    <= $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;
                    r_acc    <= '0;
                    r_mcand  <= {24'd0, 1'b1, r_a[22:0]};
                    r_mplier <= {1'b1, r_b[22:0]};
                    r_cnt    <= '0;
                end
                c_MUL: begin
                    r_acc    <= r_acc + w_pp;
                    r_mcand  <= r_mcand << ITER_BITS;
                    r_mplier <= r_mplier >> ITER_BITS;
                    r_cnt    <= r_cnt + 5'd1;
                end
                c_NORM: begin
                    if (r_acc[47]) begin
                        r_frac   <= r_acc[46:24];
                        r_guard  <= r_acc[23];
                        r_sticky <= |r_acc[22:0];
                        r_exp    <= r_exp + 10'sd1;
                    end else begin
                        r_frac   <= r_acc[45:23];
                        r_guard  <= r_acc[22];
                        r_sticky <= |r_acc[21:0];
                    end
                end
                c_ROUND: begin
                    if (w_exp_rnd >= 10'sd255) begin
                        r_product  <= {w_sign, 8'hFF, 23'd0};
                        r_overflow <= 1'b1;
                    end else if (w_exp_rnd <= 10'sd0) begin
                        r_product   <= {w_sign, 31'd0};
                        r_underflow <= 1'b1;
                    end else begin
                        r_product <= {w_sign, w_exp_rnd[7:0], w_frac_sum[22:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign product   = r_product;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

`ifdef FPM_PERF_CNT_EN
    logic [31:0] r_op_count, r_busy_cycles;

    // Handoff and non-idle cycle counters, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count    <= '0;
            r_busy_cycles <= '0;
        end else begin
            if (out_valid && out_ready) r_op_count <= r_op_count + 32'd1;
            if (r_state != c_IDLE)      r_busy_cycles <= r_busy_cycles + 32'd1;
        end
    end

    assign op_count    = r_op_count;
    assign busy_cycles = r_busy_cycles;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_mul_sequencer
//  Purpose  : Self-checking bench: directed vector table, randomized operands
//             against an arithmetic reference model, backpressure and
//             mid-operation reset sequences. Two instances (ITER_BITS 1 and 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op_a, op_b;
    logic        in_valid, out_ready;
    logic        sel4;          // 1: drive the ITER_BITS=4 instance

    logic        in_ready1, out_valid1, ovf1, unf1;
    logic        in_ready4, out_valid4, ovf4, unf4;
    logic [31:0] prod1, prod4;
    logic        in_valid1, in_valid4, out_ready1, out_ready4;
`ifdef FPM_PERF_CNT_EN
    logic [31:0] op_count1, busy1, op_count4, busy4;
`endif

    assign in_valid1  = in_valid  & ~sel4;
    assign in_valid4  = in_valid  &  sel4;
    assign out_ready1 = out_ready & ~sel4;
    assign out_ready4 = out_ready &  sel4;

    logic        m_in_ready, m_out_valid, m_ovf, m_unf;
    logic [31:0] m_product;
    assign m_in_ready  = sel4 ? in_ready4  : in_ready1;
    assign m_out_valid = sel4 ? out_valid4 : out_valid1;
    assign m_ovf       = sel4 ? ovf4       : ovf1;
    assign m_unf       = sel4 ? unf4       : unf1;
    assign m_product   = sel4 ? prod4      : prod1;

    fp_mul_sequencer #(.ITER_BITS(1)) dut (
`ifdef FPM_PERF_CNT_EN
        .op_count(op_count1), .busy_cycles(busy1),
`endif
        .clk(clk), .rst(rst), .input_a(op_a), .input_b(op_b),
        .in_valid(in_valid1), .in_ready(in_ready1), .product(prod1),
        .overflow(ovf1), .underflow(unf1), .out_valid(out_valid1),
        .out_ready(out_ready1)
    );

    fp_mul_sequencer #(.ITER_BITS(4)) dut4 (
`ifdef FPM_PERF_CNT_EN
        .op_count(op_count4), .busy_cycles(busy4),
`endif
        .clk(clk), .rst(rst), .input_a(op_a), .input_b(op_b),
        .in_valid(in_valid4), .in_ready(in_ready4), .product(prod4),
        .overflow(ovf4), .underflow(unf4), .out_valid(out_valid4),
        .out_ready(out_ready4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer product of the significands, RNE on the remainder
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b, input int n,
                                    output logic [31:0] p, output logic ovf, output logic unf,
                                    output int lat);
        int ea, eb, e, sh;
        logic s;
        longint unsigned ma, mb, prod, keep, rem, half;
        s = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ovf = 1'b0;
        unf = 1'b0;
        if (ea == 255 || eb == 255) begin
            lat = 2;
            if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) || ea == 0 || eb == 0)
                p = 32'h7FC00000;
            else
                p = {s, 8'hFF, 23'd0};
        end else if (ea == 0 || eb == 0) begin
            lat = 2;
            p = {s, 31'd0};
        end else begin
            lat  = n + 5;
            ma   = 64'(a[22:0]) + (64'd1 << 23);
            mb   = 64'(b[22:0]) + (64'd1 << 23);
            prod = ma * mb;
            e    = ea + eb - 127;
            sh   = 23;
            if (prod >= (64'd1 << 47)) begin
                sh = 24;
                e  = e + 1;
            end
            keep = prod >> sh;
            rem  = prod - (keep << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 1;
            if (keep == (64'd1 << 24)) begin
                keep = 64'd1 << 23;
                e    = e + 1;
            end
            if (e >= 255) begin
                p = {s, 8'hFF, 23'd0};
                ovf = 1'b1;
            end else if (e <= 0) begin
                p = {s, 31'd0};
                unf = 1'b1;
            end else begin
                p = {s, e[7:0], keep[22:0]};
            end
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        int k;
        logic [7:0]  e;
        logic [22:0] f;
        logic        s;
        k = int'($urandom_range(0, 15));
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        case (k)
            0:       e = 8'd0;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 20));
            3:       e = 8'($urandom_range(230, 254));
            default: e = 8'($urandom_range(90, 165));
        endcase
        if (k == 1 && $urandom_range(0, 1) == 1) f = 23'd0;
        if (k == 12) f = f & 23'h7F0000;
        if (k == 13) f = 23'h7FFFFF;
        return {s, e, f};
    endfunction

    // One transaction with out_ready held high; latency counts the accept edge as 1
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] p, output logic ovf, output logic unf,
                          output int lat);
        int guard;
        op_a = a;
        op_b = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        while (!m_in_ready && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!m_out_valid && lat < 200) begin
            tick();
            lat++;
        end
        p   = m_product;
        ovf = m_ovf;
        unf = m_unf;
        tick();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic        ovf;
        logic        unf;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [31:0] p, ep;
        logic        ovf, unf, eovf, eunf;
        int          lat, elat, seen;
        logic [31:0] ra, rb;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 29};
        vecs[1]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 29};
        vecs[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0, 29};
        vecs[3]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, 2};
        vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 2};
        vecs[5]  = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 1'b0, 2};
        vecs[6]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 29};
        vecs[7]  = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 29};
        vecs[8]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 2};
        vecs[9]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 2};
        vecs[10] = '{32'hFF800000, 32'hFF800000, 32'h7F800000, 1'b0, 1'b0, 2};
        vecs[11] = '{32'hBF800000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0, 29};
        vecs[12] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0, 1'b0, 29};

        rst = 1'b1;
        op_a = '0;
        op_b = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sel4 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("reset_in_ready", 32'(in_ready1), 32'd1);
        check("reset_out_valid", 32'(out_valid1), 32'd0);
        check("reset_product", prod1, 32'd0);
        check("reset_flags", {30'd0, ovf1, unf1}, 32'd0);
        check("reset4_in_ready", 32'(in_ready4), 32'd1);

        // Directed vectors at ITER_BITS=1
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, p, ovf, unf, lat);
            check($sformatf("vec%0d_product", i), p, vecs[i].p);
            check($sformatf("vec%0d_flags", i), {30'd0, ovf, unf}, {30'd0, vecs[i].ovf, vecs[i].unf});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // ITER_BITS=4: 1.0*1.0 in 11 edges
        sel4 = 1'b1;
        run_op(32'h3F800000, 32'h3F800000, p, ovf, unf, lat);
        check("iter4_product", p, 32'h3F800000);
        check("iter4_latency", 32'(lat), 32'd11);

        // Randomized against the reference model, both instances
        for (int i = 0; i < 300; i++) begin
            sel4 = (i >= 200);
            ra = rand_fp();
            rb = rand_fp();
            ref_mul(ra, rb, sel4 ? 6 : 24, ep, eovf, eunf, elat);
            run_op(ra, rb, p, ovf, unf, lat);
            check($sformatf("rand_product %h*%h", ra, rb), p, ep);
            check($sformatf("rand_flags %h*%h", ra, rb), {30'd0, ovf, unf}, {30'd0, eovf, eunf});
            check($sformatf("rand_latency %h*%h", ra, rb), 32'(lat), 32'(elat));
        end
        sel4 = 1'b0;

        // Backpressure: result held stable while out_ready is low
        out_ready = 1'b0;
        op_a = 32'h3FC00000;
        op_b = 32'h40000000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid1 && lat < 200) begin
            tick();
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd29);
        for (int c = 0; c < 10; c++) begin
            check("bp_product_hold", prod1, 32'h40400000);
            check("bp_out_valid_hold", 32'(out_valid1), 32'd1);
            check("bp_in_ready_low", 32'(in_ready1), 32'd0);
            check("bp_flags_hold", {30'd0, ovf1, unf1}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        op_a = 32'h40000000;
        op_b = 32'h40400000;
        in_valid = 1'b1;
        tick();
        check("bp_in_ready_after_handoff", 32'(in_ready1), 32'd1);
        check("bp_out_valid_after_handoff", 32'(out_valid1), 32'd0);
        tick();
        in_valid = 1'b0;
        check("b2b_accepted", 32'(in_ready1), 32'd0);
        lat = 1;
        while (!out_valid1 && lat < 200) begin
            tick();
            lat++;
        end
        check("b2b_product", prod1, 32'h40C00000);
        check("b2b_latency", 32'(lat), 32'd29);
        tick();

        // Reset during MUL discards the operation
        op_a = 32'h3F800000;
        op_b = 32'h40000000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready1), 32'd1);
        check("midrst_out_valid", 32'(out_valid1), 32'd0);
        check("midrst_product", prod1, 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid1) seen++;
            tick();
        end
        check("midrst_no_stale_result", 32'(seen), 32'd0);
`ifdef FPM_PERF_CNT_EN
        check("perf_op_count_reset", op_count1, 32'd0);
        check("perf_busy_idle", busy1, 32'd0);
        run_op(32'h3F800000, 32'h3F800000, p, ovf, unf, lat);
        check("perf_op_count_one", op_count1, 32'd1);
        check("perf_busy_one_op", busy1, 32'd29);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
